// File: rtl/fetch_align_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_align_buffer_if
// Bundles the program-memory fetch port, the redirect port and the decode-side
// valid/ready port of fetch_align_buffer.
//   master : the fetch/align block (drives mem_addr and out_*)
//   slave  : the surroundings (program memory, branch unit, decode)
// Signals:
//   mem_addr[31:0]    word-aligned fetch address
//   mem_rdata[31:0]   combinational read data for mem_addr
//   redirect_valid    taken branch/jump, flush and refetch
//   redirect_pc[31:0] redirect target (bit 0 ignored)
//   out_valid/ready   decode handshake
//   out_instr[31:0]   aligned instruction
//   out_pc[31:0]      byte address of out_instr
//   out_compressed    out_instr came from a 16-bit encoding
// -----------------------------------------------------------------------------
interface fetch_align_buffer_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_compressed;

   modport master (
      output mem_addr,
      input  mem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_compressed
   );

   modport slave (
      input  mem_addr,
      output mem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_compressed
   );
endinterface

// File: rtl/fetch_align_buffer.sv
// -----------------------------------------------------------------------------
// fetch_align_buffer
// Fetches word-aligned program memory, buffers the returned words as a
// halfword queue and presents one aligned instruction (16-bit RVC or 32-bit,
// including 32-bit instructions straddling a word boundary) per handshake.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      fetch_align_buffer_if.master (memory, redirect, decode ports)
// Parameters:
//   RESET_PC first byte address fetched after reset
//   QUEUE_HW halfword queue depth, 4..8
// Build option:
//   RVC_EXPAND_EN  when defined, compressed instructions are expanded to their
//                  RV32I equivalent on out_instr; otherwise out_instr carries
//                  {16'h0000, halfword} and decode expands them.
// -----------------------------------------------------------------------------
module fetch_align_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QUEUE_HW = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   fetch_align_buffer_if.master bus
);

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;

   // Queue entry 0 (bits [15:0]) is the halfword at head_pc.
   logic [QUEUE_HW*16-1:0] q;
   logic [QUEUE_HW*16-1:0] q_next;
   logic [3:0]             count;
   logic [29:0]            fetch_ptr;
   logic                   drop_low;
   logic [31:0]            head_pc;

   logic [15:0] head;
   logic        is_wide;
   logic [3:0]  need;
   logic        valid;
   logic        pop;
   logic [3:0]  pop_n;
   logic [3:0]  rest;
   logic        push;

   // A redirect target's bit 0 carries no information for halfword fetch.
   logic unused_pc_bit0;
   assign unused_pc_bit0 = bus.redirect_pc[0];

`ifdef RVC_EXPAND_EN
   function automatic logic [31:0] expand_rvc(input logic [15:0] h);
      logic [4:0]  rd;
      logic [4:0]  rs2;
      logic [4:0]  rdp;
      logic [4:0]  rs1p;
      logic [11:0] imm6;
      logic [11:0] moff;
      logic [31:0] r;
      rd   = h[11:7];
      rs2  = h[6:2];
      rdp  = {2'b01, h[4:2]};
      rs1p = {2'b01, h[9:7]};
      imm6 = {{6{h[12]}}, h[12], h[6:2]};
      moff = {5'b0, h[5], h[12:10], h[6], 2'b00};
      r    = 32'h0000_0000;
      case (h[1:0])
         2'b00: begin
            if (h[15:13] == 3'b010)
               r = {moff, rs1p, 3'b010, rdp, 7'b0000011};               // c.lw
            else if (h[15:13] == 3'b110)
               r = {moff[11:5], rdp, rs1p, 3'b010, moff[4:0], 7'b0100011}; // c.sw
         end
         2'b01: begin
            case (h[15:13])
               3'b000: r = {imm6, rd, 3'b000, rd, OP_IMM};            // c.addi/c.nop
               3'b010: r = {imm6, 5'd0, 3'b000, rd, OP_IMM};          // c.li
               3'b011: begin                                          // c.lui
                  if (rd != 5'd0 && rd != 5'd2 && {h[12], h[6:2]} != 6'd0)
                     r = {{14{h[12]}}, h[12], h[6:2], rd, 7'b0110111};
               end
               3'b100: begin
                  case (h[11:10])
                     2'b00: if (!h[12]) r = {7'b0000000, rs2, rs1p, 3'b101, rs1p, OP_IMM}; // c.srli
                     2'b01: if (!h[12]) r = {7'b0100000, rs2, rs1p, 3'b101, rs1p, OP_IMM}; // c.srai
                     2'b10: r = {imm6, rs1p, 3'b111, rs1p, OP_IMM};                        // c.andi
                     default: begin
                        if (!h[12]) begin
                           case (h[6:5])
                              2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG}; // c.sub
                              2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG}; // c.xor
                              2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG}; // c.or
                              default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG}; // c.and
                           endcase
                        end
                     end
                  endcase
               end
               default: r = 32'h0000_0000;
            endcase
         end
         2'b10: begin
            if (h[15:13] == 3'b000 && !h[12])
               r = {7'b0000000, rs2, rd, 3'b001, rd, OP_IMM};          // c.slli
            else if (h[15:13] == 3'b100 && rs2 != 5'd0)
               r = h[12] ? {7'b0000000, rs2, rd, 3'b000, rd, OP_REG}   // c.add
                         : {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG}; // c.mv
         end
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction
`else
   function automatic logic [31:0] expand_rvc(input logic [15:0] h);
      return {16'h0000, h};
   endfunction
`endif

   // Head classification and handshake / fetch decisions.
   always_comb begin
      head    = q[15:0];
      is_wide = (head[1:0] == 2'b11);
      need    = is_wide ? 4'd2 : 4'd1;
      valid   = (count >= need) && !bus.redirect_valid;
      pop     = valid && bus.out_ready;
      pop_n   = pop ? need : 4'd0;
      rest    = count - pop_n;
      push    = (rest <= 4'(QUEUE_HW - 2)) && !bus.redirect_valid;
   end

   // Shift out consumed halfwords, then append the fetched word behind the
   // survivors. Slots past the new count are don't-care.
   // NOTE: every combinational output gets a value before any condition, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      q_next = q >> {pop_n, 4'b0000};
      for (int i = 0; i < QUEUE_HW; i++) begin
         if (push) begin
            if (drop_low) begin
               if (4'(i) == rest) q_next[i*16 +: 16] = bus.mem_rdata[31:16];
            end else begin
               if (4'(i) == rest)        q_next[i*16 +: 16] = bus.mem_rdata[15:0];
               if (4'(i) == rest + 4'd1) q_next[i*16 +: 16] = bus.mem_rdata[31:16];
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order. The small halfword
   // array is reset along with the control state so out_instr never derives
   // from uninitialised storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q         <= '0;
         count     <= '0;
         fetch_ptr <= RESET_PC[31:2];
         drop_low  <= RESET_PC[1];
         head_pc   <= RESET_PC;
      end else if (bus.redirect_valid) begin
         count     <= '0;
         head_pc   <= {bus.redirect_pc[31:1], 1'b0};
         fetch_ptr <= bus.redirect_pc[31:2];
         drop_low  <= bus.redirect_pc[1];
      end else begin
         q     <= q_next;
         count <= rest + (push ? (drop_low ? 4'd1 : 4'd2) : 4'd0);
         if (pop)
            head_pc <= head_pc + (is_wide ? 32'd4 : 32'd2);
         if (push) begin
            fetch_ptr <= fetch_ptr + 30'd1;
            drop_low  <= 1'b0;
         end
      end
   end

   assign bus.mem_addr       = {fetch_ptr, 2'b00};
   assign bus.out_valid      = valid;
   assign bus.out_pc         = valid ? head_pc : 32'h0000_0000;
   assign bus.out_compressed = valid && !is_wide;
   assign bus.out_instr      = !valid ? 32'h0000_0000 :
                               is_wide ? q[31:0] : expand_rvc(head);

endmodule
